// File: rtl/scariv_ras_stack_ckpt.sv
// Speculative return address stack with checkpoint (tos, count) export and
// flush-time restore/repair for mispredict recovery.
module scariv_ras_stack_ckpt #(
    parameter int RAS_DEPTH = 8,
    parameter int VADDR_W   = 39,
    parameter int IDX_W     = $clog2(RAS_DEPTH),
    parameter int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_push_valid,
    input  logic [VADDR_W-2:0] i_push_vaddr,
    input  logic               i_pop_valid,
    input  logic               i_flush_valid,
    input  logic [IDX_W-1:0]   i_flush_index,
    input  logic [CNT_W-1:0]   i_flush_count,
    input  logic               i_flush_repair,
    input  logic [VADDR_W-2:0] i_flush_vaddr,
    output logic               o_top_valid,
    output logic [VADDR_W-2:0] o_top_vaddr,
    output logic [IDX_W-1:0]   o_top_index,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_overflow,
    output logic               o_underflow
);

    localparam logic [CNT_W-1:0] DepthC = CNT_W'(RAS_DEPTH);

    logic [VADDR_W-2:0] entry_q [RAS_DEPTH];
    logic [VADDR_W-2:0] entry_d [RAS_DEPTH];
    logic [IDX_W-1:0]   tos_q, tos_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic [IDX_W-1:0]   tos_inc;
    logic [IDX_W-1:0]   tos_dec;
    logic               stack_full;
    logic               stack_empty;

    assign tos_inc     = tos_q + IDX_W'(1);
    assign tos_dec     = tos_q - IDX_W'(1);
    assign stack_full  = (count_q == DepthC);
    assign stack_empty = (count_q == '0);

    // One action per cycle: flush beats push+pop, which beats push, which beats pop.
    always_comb begin
        entry_d     = entry_q;
        tos_d       = tos_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        if (i_flush_valid) begin
            tos_d   = i_flush_index;
            count_d = (i_flush_count > DepthC) ? DepthC : i_flush_count;
            if (i_flush_repair) begin
                entry_d[i_flush_index] = i_flush_vaddr;
            end
        end else if (i_push_valid && i_pop_valid) begin
            entry_d[tos_q] = i_push_vaddr;
            if (stack_empty) begin
                count_d = CNT_W'(1);
            end
        end else if (i_push_valid) begin
            tos_d            = tos_inc;
            entry_d[tos_inc] = i_push_vaddr;
            if (stack_full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (i_pop_valid) begin
            // Popped entries stay in the array so an older checkpoint can recover them.
            if (stack_empty) begin
                underflow_d = 1'b1;
            end else begin
                tos_d   = tos_dec;
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            tos_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            tos_q       <= tos_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_top_valid = !stack_empty;
    assign o_top_vaddr = stack_empty ? '0 : entry_q[tos_q];
    assign o_top_index = tos_q;
    assign o_count     = count_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule
